// File: rtl/qseq_pkg.sv
// Shared types and encodings for the Q/Q2 gate-operation sequencer.
package qseq_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INIT      = 3'd1,
        ROT_FWD   = 3'd2,
        MULT_WAIT = 3'd3,
        ROT_BACK  = 3'd4,
        DONE      = 3'd5
    } qseq_state_t;

    localparam logic LOAD     = 1'b0;
    localparam logic ROTATE   = 1'b1;
    localparam logic MUX_P    = 1'b0;
    localparam logic MUX_MULT = 1'b1;

endpackage

// File: rtl/qseq_rot_counter.sv
// Loadable down-counter with zero flag; times both the forward and back rotations.
module qseq_rot_counter
    import qseq_pkg::*;
#(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst_new,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst_new) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_cnt  = r_cnt;
    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/q_op_sequencer.sv
// Sequences the Q/Q2 bank through init, forward rotate, multiply beats, rotate back.
// Optional beat counter output enabled by defining QSEQ_BEAT_CNT_EN.
module q_op_sequencer
    import qseq_pkg::*;
#(
    parameter int num_qubit  = 4,
    parameter int max_vector = 2**num_qubit,
    parameter int TGT_W      = $clog2(num_qubit)
) (
    input  logic                    clk,
    input  logic                    rst_new,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [TGT_W-1:0]        cmd_tgt,
    input  logic                    cmd_no_mult,
    input  logic                    mult_valid,
    output logic                    mult_ready,
    input  logic                    mult_last,
    input  logic [0:max_vector-1]   mult_en_Q,
    input  logic [0:max_vector-1]   mult_en_Q2,
    output logic [0:max_vector-1]   ld_Q,
    output logic [0:max_vector-1]   ld_Q2,
    output logic                    load_rotate_Q,
    output logic                    load_Q_mux,
    output logic                    busy,
    output logic                    done,
    output logic                    cmd_err
`ifdef QSEQ_BEAT_CNT_EN
    ,
    output logic [$clog2(max_vector):0] beat_cnt
`endif
);

    localparam int CNT_W = (num_qubit > 2) ? $clog2(num_qubit) : 1;

    qseq_state_t      r_state;
    qseq_state_t      w_state_nxt;
    logic [TGT_W-1:0] r_tgt;
    logic             r_no_mult;
    logic             r_err;
    logic             w_accept;
    logic             w_bad_tgt;
    logic             w_cnt_load;
    logic             w_cnt_dec;
    logic [CNT_W-1:0] w_cnt_val;
    logic [CNT_W-1:0] w_cnt;
    logic             w_cnt_zero;
    logic             w_tgt_nz;

    assign w_bad_tgt = (int'(cmd_tgt) >= num_qubit);
    assign w_tgt_nz  = (r_tgt != '0);
    assign cmd_err   = r_err;

    qseq_rot_counter #(
        .CNT_W (CNT_W)
    ) u_rot_cnt (
        .clk        (clk),
        .rst_new    (rst_new),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_val),
        .i_dec      (w_cnt_dec),
        .o_cnt      (w_cnt),
        .o_zero     (w_cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (rst_new) begin
            r_state   <= IDLE;
            r_tgt     <= '0;
            r_no_mult <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_err   <= w_accept && w_bad_tgt;
            if (w_accept) begin
                r_tgt     <= cmd_tgt;
                r_no_mult <= cmd_no_mult;
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        cmd_ready     = 1'b0;
        busy          = 1'b1;
        done          = 1'b0;
        mult_ready    = 1'b0;
        ld_Q          = '0;
        ld_Q2         = '0;
        load_rotate_Q = LOAD;
        load_Q_mux    = MUX_P;
        w_accept      = 1'b0;
        w_cnt_load    = 1'b0;
        w_cnt_dec     = 1'b0;
        w_cnt_val     = '0;
        case (r_state)
            IDLE: begin
                busy      = 1'b0;
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    w_accept = 1'b1;
                    if (!w_bad_tgt) begin
                        w_state_nxt = INIT;
                    end
                end
            end
            INIT: begin
                ld_Q  = '1;
                ld_Q2 = '1;
                if (w_tgt_nz) begin
                    w_state_nxt = ROT_FWD;
                    w_cnt_load  = 1'b1;
                    w_cnt_val   = CNT_W'(int'(r_tgt) - 1);
                end else if (r_no_mult) begin
                    w_state_nxt = DONE;
                end else begin
                    w_state_nxt = MULT_WAIT;
                end
            end
            ROT_FWD: begin
                ld_Q          = '1;
                ld_Q2         = '1;
                load_rotate_Q = ROTATE;
                if (!w_cnt_zero) begin
                    w_cnt_dec = 1'b1;
                end else if (r_no_mult) begin
                    w_state_nxt = ROT_BACK;
                    w_cnt_load  = 1'b1;
                    w_cnt_val   = CNT_W'(num_qubit - int'(r_tgt) - 1);
                end else begin
                    w_state_nxt = MULT_WAIT;
                end
            end
            MULT_WAIT: begin
                mult_ready = 1'b1;
                load_Q_mux = MUX_MULT;
                if (mult_valid) begin
                    ld_Q  = mult_en_Q;
                    ld_Q2 = mult_en_Q2;
                    if (mult_last) begin
                        if (w_tgt_nz) begin
                            w_state_nxt = ROT_BACK;
                            w_cnt_load  = 1'b1;
                            w_cnt_val   = CNT_W'(num_qubit - int'(r_tgt) - 1);
                        end else begin
                            w_state_nxt = DONE;
                        end
                    end
                end
            end
            ROT_BACK: begin
                // Back rotation completes a full num_qubit turn, restoring column order.
                ld_Q          = '1;
                ld_Q2         = '1;
                load_rotate_Q = ROTATE;
                if (w_cnt_zero) begin
                    w_state_nxt = DONE;
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
            DONE: begin
                done        = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

`ifdef QSEQ_BEAT_CNT_EN
    logic [$clog2(max_vector):0] r_beat_cnt;
    logic                        w_beat;

    assign w_beat   = (r_state == MULT_WAIT) && mult_valid;
    assign beat_cnt = r_beat_cnt;

    always_ff @(posedge clk) begin
        if (rst_new) begin
            r_beat_cnt <= '0;
        end else if (w_accept) begin
            r_beat_cnt <= '0;
        end else if (w_beat && (r_beat_cnt != '1)) begin
            r_beat_cnt <= r_beat_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_q_op_sequencer.sv
// Directed self-checking bench for q_op_sequencer (num_qubit = 4, max_vector = 16).
module tb_q_op_sequencer;

    localparam int NQ = 4;
    localparam int MV = 16;
    localparam int TW = 3;

    logic          clk = 1'b0;
    logic          rst_new;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [TW-1:0] cmd_tgt;
    logic          cmd_no_mult;
    logic          mult_valid;
    logic          mult_ready;
    logic          mult_last;
    logic [0:MV-1] mult_en_Q;
    logic [0:MV-1] mult_en_Q2;
    logic [0:MV-1] ld_Q;
    logic [0:MV-1] ld_Q2;
    logic          load_rotate_Q;
    logic          load_Q_mux;
    logic          busy;
    logic          done;
    logic          cmd_err;
`ifdef QSEQ_BEAT_CNT_EN
    logic [4:0]    beat_cnt;
`endif

    int n_total = 0;
    int n_bad   = 0;

    q_op_sequencer #(
        .num_qubit  (NQ),
        .max_vector (MV),
        .TGT_W      (TW)
    ) dut (
        .clk           (clk),
        .rst_new       (rst_new),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_tgt       (cmd_tgt),
        .cmd_no_mult   (cmd_no_mult),
        .mult_valid    (mult_valid),
        .mult_ready    (mult_ready),
        .mult_last     (mult_last),
        .mult_en_Q     (mult_en_Q),
        .mult_en_Q2    (mult_en_Q2),
        .ld_Q          (ld_Q),
        .ld_Q2         (ld_Q2),
        .load_rotate_Q (load_rotate_Q),
        .load_Q_mux    (load_Q_mux),
        .busy          (busy),
        .done          (done),
        .cmd_err       (cmd_err)
`ifdef QSEQ_BEAT_CNT_EN
        ,
        .beat_cnt      (beat_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        #1;
    endtask

    // Checks the common rotate-phase outputs: all rows loading, rotate select, P mux.
    task automatic chk_rot(input string tag);
        check({tag, ".rot"}, 32'(load_rotate_Q), 32'd1);
        check({tag, ".ldQ"}, 32'(ld_Q), 32'h0000FFFF);
        check({tag, ".ldQ2"}, 32'(ld_Q2), 32'h0000FFFF);
        check({tag, ".mux"}, 32'(load_Q_mux), 32'd0);
        check({tag, ".done"}, 32'(done), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_new     = 1'b1;
        cmd_valid   = 1'b0;
        cmd_tgt     = '0;
        cmd_no_mult = 1'b0;
        mult_valid  = 1'b0;
        mult_last   = 1'b0;
        mult_en_Q   = '0;
        mult_en_Q2  = '0;
        repeat (2) cyc();
        smp();
        check("rst.ready", 32'(cmd_ready), 32'd1);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.done", 32'(done), 32'd0);
        check("rst.err", 32'(cmd_err), 32'd0);
        check("rst.ldQ", 32'(ld_Q), 32'd0);
        check("rst.ldQ2", 32'(ld_Q2), 32'd0);
        check("rst.rot", 32'(load_rotate_Q), 32'd0);
        check("rst.mux", 32'(load_Q_mux), 32'd0);
        check("rst.mready", 32'(mult_ready), 32'd0);
        rst_new = 1'b0;

        // tgt=2, three full-mask beats: INIT, 2 fwd, 3 mult, 2 back, DONE
        cyc();
        cmd_valid = 1'b1; cmd_tgt = 3'd2; cmd_no_mult = 1'b0;
        smp();
        check("t1.accept_ready", 32'(cmd_ready), 32'd1);
        cyc();
        cmd_valid = 1'b0;
        smp();
        check("t1.init_ldQ", 32'(ld_Q), 32'h0000FFFF);
        check("t1.init_ldQ2", 32'(ld_Q2), 32'h0000FFFF);
        check("t1.init_rot", 32'(load_rotate_Q), 32'd0);
        check("t1.init_mux", 32'(load_Q_mux), 32'd0);
        check("t1.init_busy", 32'(busy), 32'd1);
        check("t1.init_ready", 32'(cmd_ready), 32'd0);
        cyc();
        mult_valid = 1'b1; mult_last = 1'b0; mult_en_Q = 16'hFFFF; mult_en_Q2 = 16'hFFFF;
        smp();
        chk_rot("t1.fwd1");
        check("t1.fwd1_mready", 32'(mult_ready), 32'd0);
        cyc();
        mult_valid = 1'b0;
        smp();
        chk_rot("t1.fwd2");
        for (int b = 0; b < 3; b++) begin
            cyc();
            mult_valid = 1'b1;
            mult_last  = (b == 2);
            smp();
            check("t1.beat_mready", 32'(mult_ready), 32'd1);
            check("t1.beat_mux", 32'(load_Q_mux), 32'd1);
            check("t1.beat_rot", 32'(load_rotate_Q), 32'd0);
            check("t1.beat_ldQ", 32'(ld_Q), 32'h0000FFFF);
            check("t1.beat_done", 32'(done), 32'd0);
        end
        cyc();
        mult_valid = 1'b0; mult_last = 1'b0;
        smp();
        chk_rot("t1.back1");
        cyc();
        smp();
        chk_rot("t1.back2");
        cyc();
        smp();
        check("t1.done", 32'(done), 32'd1);
        check("t1.done_ldQ", 32'(ld_Q), 32'd0);
        check("t1.done_busy", 32'(busy), 32'd1);
        cyc();
        smp();
        check("t1.idle_done", 32'(done), 32'd0);
        check("t1.idle_busy", 32'(busy), 32'd0);
        check("t1.idle_ready", 32'(cmd_ready), 32'd1);

        // tgt=0, no_mult: INIT then DONE, never rotates
        cmd_valid = 1'b1; cmd_tgt = 3'd0; cmd_no_mult = 1'b1;
        cyc();
        cmd_valid = 1'b0;
        smp();
        check("t2.init_ldQ", 32'(ld_Q), 32'h0000FFFF);
        check("t2.init_rot", 32'(load_rotate_Q), 32'd0);
        check("t2.init_done", 32'(done), 32'd0);
        cyc();
        smp();
        check("t2.done", 32'(done), 32'd1);
        check("t2.done_rot", 32'(load_rotate_Q), 32'd0);
        cyc();
        smp();
        check("t2.idle_ready", 32'(cmd_ready), 32'd1);

        // tgt=5 is out of range
        cmd_valid = 1'b1; cmd_tgt = 3'd5; cmd_no_mult = 1'b0;
        smp();
        check("t3.accept_ldQ", 32'(ld_Q), 32'd0);
        cyc();
        cmd_valid = 1'b0;
        smp();
        check("t3.err", 32'(cmd_err), 32'd1);
        check("t3.err_ready", 32'(cmd_ready), 32'd1);
        check("t3.err_busy", 32'(busy), 32'd0);
        check("t3.err_ldQ", 32'(ld_Q), 32'd0);
        check("t3.err_ldQ2", 32'(ld_Q2), 32'd0);
        cyc();
        smp();
        check("t3.err_clear", 32'(cmd_err), 32'd0);
        check("t3.still_idle", 32'(busy), 32'd0);

        // tgt=1 with gapped beats and sparse masks, then 3 back-rotations
        cmd_valid = 1'b1; cmd_tgt = 3'd1; cmd_no_mult = 1'b0;
        mult_en_Q = 16'h0003; mult_en_Q2 = 16'h8000;
        cyc();
        cmd_valid = 1'b0;
        cyc();
        smp();
        chk_rot("t4.fwd1");
        cyc();
        mult_valid = 1'b1; mult_last = 1'b0;
        smp();
        check("t4.b1_ldQ", 32'(ld_Q), 32'h00000003);
        check("t4.b1_ldQ2", 32'(ld_Q2), 32'h00008000);
        check("t4.b1_mready", 32'(mult_ready), 32'd1);
        cyc();
        mult_valid = 1'b0;
        smp();
        check("t4.gap_ldQ", 32'(ld_Q), 32'd0);
        check("t4.gap_ldQ2", 32'(ld_Q2), 32'd0);
        check("t4.gap_mux", 32'(load_Q_mux), 32'd1);
        check("t4.gap_mready", 32'(mult_ready), 32'd1);
        cyc();
        mult_valid = 1'b1; mult_last = 1'b1;
        smp();
        check("t4.b2_ldQ", 32'(ld_Q), 32'h00000003);
        check("t4.b2_ldQ2", 32'(ld_Q2), 32'h00008000);
        for (int r = 0; r < 3; r++) begin
            cyc();
            mult_valid = 1'b0; mult_last = 1'b0;
            smp();
            chk_rot("t4.back");
        end
        cyc();
        smp();
        check("t4.done", 32'(done), 32'd1);
        cyc();

        // reset during the second forward rotation of tgt=3
        cmd_valid = 1'b1; cmd_tgt = 3'd3; cmd_no_mult = 1'b0;
        cyc();
        cmd_valid = 1'b0;
        cyc();
        smp();
        chk_rot("t5.fwd1");
        cyc();
        rst_new = 1'b1;
        smp();
        check("t5.fwd2_rot", 32'(load_rotate_Q), 32'd1);
        cyc();
        rst_new = 1'b0;
        smp();
        check("t5.rst_busy", 32'(busy), 32'd0);
        check("t5.rst_ready", 32'(cmd_ready), 32'd1);
        check("t5.rst_ldQ", 32'(ld_Q), 32'd0);
        check("t5.rst_ldQ2", 32'(ld_Q2), 32'd0);
        check("t5.rst_rot", 32'(load_rotate_Q), 32'd0);

        // cmd_valid held high; tgt=0 with three zero-mask beats
        cmd_valid = 1'b1; cmd_tgt = 3'd0; cmd_no_mult = 1'b0;
        mult_en_Q = '0; mult_en_Q2 = '0;
        cyc();
        smp();
        check("t6.init_ready", 32'(cmd_ready), 32'd0);
        for (int b = 0; b < 3; b++) begin
            cyc();
            mult_valid = 1'b1;
            mult_last  = (b == 2);
            smp();
            check("t6.beat_ready", 32'(cmd_ready), 32'd0);
            check("t6.beat_ldQ", 32'(ld_Q), 32'd0);
        end
        cyc();
        mult_valid = 1'b0; mult_last = 1'b0; cmd_no_mult = 1'b1;
        smp();
        check("t6.done", 32'(done), 32'd1);
        check("t6.done_ready", 32'(cmd_ready), 32'd0);
`ifdef QSEQ_BEAT_CNT_EN
        check("t6.bcnt_done", 32'(beat_cnt), 32'd3);
`endif
        cyc();
        smp();
        check("t6.idle_ready", 32'(cmd_ready), 32'd1);
`ifdef QSEQ_BEAT_CNT_EN
        check("t6.bcnt_hold", 32'(beat_cnt), 32'd3);
`endif
        cyc();
        cmd_valid = 1'b0;
        smp();
        check("t6.second_busy", 32'(busy), 32'd1);
        check("t6.second_init", 32'(ld_Q), 32'h0000FFFF);
`ifdef QSEQ_BEAT_CNT_EN
        check("t6.bcnt_clear", 32'(beat_cnt), 32'd0);
`endif
        cyc();
        smp();
        check("t6.second_done", 32'(done), 32'd1);
        cyc();

`ifdef QSEQ_BEAT_CNT_EN
        // 33 beats saturate the 5-bit counter at 31
        cmd_valid = 1'b1; cmd_tgt = 3'd0; cmd_no_mult = 1'b0;
        cyc();
        cmd_valid = 1'b0;
        for (int b = 0; b < 33; b++) begin
            cyc();
            mult_valid = 1'b1;
            mult_last  = (b == 32);
        end
        cyc();
        mult_valid = 1'b0; mult_last = 1'b0;
        smp();
        check("t7.sat_done", 32'(done), 32'd1);
        check("t7.bcnt_sat", 32'(beat_cnt), 32'd31);
        cyc();
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
